// File: rtl/dmem_pkg.sv
// Shared types for the data-memory controller: access sizes, FSM states and
// the alignment helper used when DMEM_MISALIGN_TRAP_EN is defined.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_e;

  // True when the low address bits do not match the natural alignment of size.
  function automatic logic is_misaligned(input size_e size, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane logic: extracts and extends the addressed lane for loads,
// and merges right-aligned store data into the old word with byte enables.
// Half accesses pick the lane from addr_lo[1] only; word accesses ignore addr_lo.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] new_word,
  output logic [3:0]  byte_en
);

  logic [7:0]  lane8;
  logic [15:0] lane16;
  logic [31:0] wrep;

  // Load extraction/extension and byte-enable generation per access size.
  always_comb begin
    load_data = '0;
    byte_en   = '0;
    lane8     = '0;
    lane16    = '0;
    wrep      = wdata;
    case (size)
      SZ_BYTE: begin
        lane8     = 8'(old_word >> {addr_lo, 3'b000});
        load_data = is_unsigned ? {24'h0, lane8} : {{24{lane8[7]}}, lane8};
        byte_en   = 4'b0001 << addr_lo;
        wrep      = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        lane16    = 16'(old_word >> {addr_lo[1], 4'b0000});
        load_data = is_unsigned ? {16'h0, lane16} : {{16{lane16[15]}}, lane16};
        byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
        wrep      = {2{wdata[15:0]}};
      end
      SZ_WORD: begin
        load_data = old_word;
        byte_en   = 4'b1111;
      end
      default: begin
        load_data = '0;
        byte_en   = '0;
      end
    endcase
  end

  // Byte-wise merge: enabled bytes take store data, the rest keep old contents.
  always_comb begin
    new_word = old_word;
    for (int b = 0; b < 4; b++) begin
      if (byte_en[b]) new_word[b*8 +: 8] = wrep[b*8 +: 8];
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: DEPTH x 32-bit storage cleared by an INIT sweep after
// reset, then one load/store per cycle with a registered response a cycle later.
// Handshake: a request transfers on a clock edge where req_valid && req_ready;
// req_ready depends only on FSM state, and responses are never backpressured.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN (misaligned accesses fault).
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = $clog2(DEPTH) + 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  init_done
);

  localparam int IW = ADDR_WIDTH - 2;
  localparam int MW = $clog2(DEPTH);

  state_e         state, state_next;
  logic [MW-1:0]  cnt, cnt_next;
  logic [31:0]    mem [DEPTH];

  size_e          size;
  logic [IW-1:0]  word_idx;
  logic [MW-1:0]  mem_idx;
  logic           range_err, size_err, misalign_err, acc_err;
  logic           accept, do_write;
  logic [31:0]    old_word, load_data, new_word;
  logic [3:0]     byte_en;

  assign size      = size_e'(req_size);
  assign word_idx  = req_addr[ADDR_WIDTH-1:2];
  assign mem_idx   = word_idx[MW-1:0];
  assign range_err = ({1'b0, word_idx} >= (IW+1)'(DEPTH));
  assign size_err  = (size == SZ_RSVD);
`ifdef DMEM_MISALIGN_TRAP_EN
  assign misalign_err = is_misaligned(size, req_addr[1:0]);
`else
  assign misalign_err = 1'b0;
`endif
  assign acc_err  = range_err | size_err | misalign_err;
  assign accept   = req_valid & req_ready;
  assign do_write = accept & req_we & ~acc_err & (|byte_en);
  assign old_word = range_err ? '0 : mem[mem_idx];

  dmem_lane_align u_lane (
    .size        (size),
    .addr_lo     (req_addr[1:0]),
    .is_unsigned (req_unsigned),
    .old_word    (old_word),
    .wdata       (req_wdata),
    .load_data   (load_data),
    .new_word    (new_word),
    .byte_en     (byte_en)
  );

  // FSM state and clear counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic: sweep the clear counter, then sit in READY.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    req_ready  = 1'b0;
    init_done  = 1'b0;
    case (state)
      INIT: begin
        cnt_next = cnt + 1'b1;
        if (cnt == MW'(DEPTH - 1)) begin
          state_next = READY;
          cnt_next   = '0;
        end
      end
      READY: begin
        req_ready = 1'b1;
        init_done = 1'b1;
      end
      default: state_next = INIT;
    endcase
  end

  // Storage writes: clear sweep during INIT, lane-merged stores in READY.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT) mem[cnt] <= '0;
      else if (do_write) mem[mem_idx] <= new_word;
    end
  end

  // Response registers: strobe per accepted request, data/err hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= accept;
      if (accept) begin
        rsp_err   <= acc_err;
        rsp_rdata <= (acc_err | req_we) ? '0 : load_data;
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl. ADDR_WIDTH is widened by one bit so a word
// index equal to DEPTH can be presented for the out-of-range fault.
module tb_dmem_ctrl;

  localparam int DEPTH = 32;
  localparam int AW    = 8;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          init_done;

  int n_checks = 0;
  int n_errs   = 0;
  int cyc;
  int spurious;

  dmem_ctrl #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .init_done    (init_done)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request, presented at negedge, sampled 1 time unit after the accepting edge.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [AW-1:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Wait for req_ready with a bound; returns edges elapsed and spurious responses.
  task automatic wait_ready(output int edges, output int spur);
    edges = 0;
    spur  = 0;
    while (req_ready !== 1'b1 && edges < 200) begin
      @(posedge clk);
      #1;
      edges++;
      if (rsp_valid !== 1'b0) spur++;
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b10;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'h0, req_ready}, 32'h0);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err",   {31'h0, rsp_err}, 32'h0);
    chk("rst_init_done", {31'h0, init_done}, 32'h0);

    // Release reset with a word load @0 held throughout the clear.
    @(negedge clk);
    rst = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 8'h00;
    wait_ready(cyc, spurious);
    chk("init_cycles", cyc, DEPTH);
    chk("init_no_rsp", spurious, 0);
    chk("init_done_hi", {31'h0, init_done}, 32'h1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("first_ld_valid", {31'h0, rsp_valid}, 32'h1);
    chk("first_ld_data", rsp_rdata, 32'h0);
    chk("first_ld_err", {31'h0, rsp_err}, 32'h0);

    // Lane extraction and extension.
    do_req(1'b1, 2'b10, 1'b0, 8'h04, 32'h80FF7F01);
    chk("st_w_valid", {31'h0, rsp_valid}, 32'h1);
    chk("st_w_rdata", rsp_rdata, 32'h0);
    do_req(1'b0, 2'b00, 1'b0, 8'h04, 32'h0);
    chk("ld_b4_s", rsp_rdata, 32'h00000001);
    do_req(1'b0, 2'b00, 1'b0, 8'h07, 32'h0);
    chk("ld_b7_s", rsp_rdata, 32'hFFFFFF80);
    do_req(1'b0, 2'b00, 1'b1, 8'h07, 32'h0);
    chk("ld_b7_u", rsp_rdata, 32'h00000080);
    do_req(1'b0, 2'b00, 1'b1, 8'h05, 32'h0);
    chk("ld_b5_u", rsp_rdata, 32'h0000007F);
    do_req(1'b0, 2'b01, 1'b1, 8'h06, 32'h0);
    chk("ld_h6_u", rsp_rdata, 32'h000080FF);
    do_req(1'b0, 2'b01, 1'b0, 8'h06, 32'h0);
    chk("ld_h6_s", rsp_rdata, 32'hFFFF80FF);
    do_req(1'b0, 2'b01, 1'b0, 8'h04, 32'h0);
    chk("ld_h4_s", rsp_rdata, 32'h00007F01);

    // Partial stores preserve untouched bytes.
    do_req(1'b1, 2'b10, 1'b0, 8'h08, 32'h11223344);
    do_req(1'b1, 2'b00, 1'b0, 8'h09, 32'h123456AA);
    do_req(1'b0, 2'b10, 1'b0, 8'h08, 32'h0);
    chk("st_b9_merge", rsp_rdata, 32'h1122AA44);
    do_req(1'b1, 2'b01, 1'b0, 8'h0A, 32'hFFFFBEEF);
    do_req(1'b0, 2'b10, 1'b0, 8'h08, 32'h0);
    chk("st_hA_merge", rsp_rdata, 32'hBEEFAA44);

    // Back-to-back store then load to the same word.
    do_req(1'b1, 2'b10, 1'b0, 8'h10, 32'hDEADBEEF);
    chk("b2b_st_valid", {31'h0, rsp_valid}, 32'h1);
    do_req(1'b0, 2'b10, 1'b0, 8'h10, 32'h0);
    chk("b2b_ld_valid", {31'h0, rsp_valid}, 32'h1);
    chk("b2b_ld_data", rsp_rdata, 32'hDEADBEEF);
    idle_cycle();
    chk("idle_valid", {31'h0, rsp_valid}, 32'h0);
    chk("idle_hold", rsp_rdata, 32'hDEADBEEF);

    // Faults.
    do_req(1'b0, 2'b10, 1'b0, 8'h80, 32'h0);
    chk("range_err", {31'h0, rsp_err}, 32'h1);
    chk("range_rdata", rsp_rdata, 32'h0);
    do_req(1'b1, 2'b11, 1'b0, 8'h0C, 32'h55555555);
    chk("rsvd_st_err", {31'h0, rsp_err}, 32'h1);
    do_req(1'b0, 2'b10, 1'b0, 8'h0C, 32'h0);
    chk("rsvd_no_write", rsp_rdata, 32'h0);
    chk("err_cleared", {31'h0, rsp_err}, 32'h0);
    do_req(1'b0, 2'b11, 1'b0, 8'h10, 32'h0);
    chk("rsvd_ld_err", {31'h0, rsp_err}, 32'h1);
    chk("rsvd_ld_rdata", rsp_rdata, 32'h0);

    // Misalignment.
    do_req(1'b1, 2'b10, 1'b0, 8'h00, 32'hCAFEF00D);
    do_req(1'b0, 2'b10, 1'b0, 8'h02, 32'h0);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("mis_w_err", {31'h0, rsp_err}, 32'h1);
    chk("mis_w_rdata", rsp_rdata, 32'h0);
`else
    chk("mis_w_err", {31'h0, rsp_err}, 32'h0);
    chk("mis_w_rdata", rsp_rdata, 32'hCAFEF00D);
`endif
    do_req(1'b0, 2'b01, 1'b1, 8'h05, 32'h0);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("mis_h_err", {31'h0, rsp_err}, 32'h1);
    chk("mis_h_rdata", rsp_rdata, 32'h0);
`else
    chk("mis_h_err", {31'h0, rsp_err}, 32'h0);
    chk("mis_h_rdata", rsp_rdata, 32'h00007F01);
`endif

    // Reset the cycle after accepting a load.
    do_req(1'b0, 2'b10, 1'b0, 8'h10, 32'h0);
    chk("pre_rst_valid", {31'h0, rsp_valid}, 32'h1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_valid", {31'h0, rsp_valid}, 32'h0);
    chk("mid_rst_init_done", {31'h0, init_done}, 32'h0);
    chk("mid_rst_ready", {31'h0, req_ready}, 32'h0);
    chk("mid_rst_rdata", rsp_rdata, 32'h0);

    // Interrupt the clear partway; it must restart from zero.
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_ready(cyc, spurious);
    chk("reinit_cycles", cyc, DEPTH);
    do_req(1'b0, 2'b10, 1'b0, 8'h10, 32'h0);
    chk("reinit_ld10_valid", {31'h0, rsp_valid}, 32'h1);
    chk("reinit_ld10", rsp_rdata, 32'h0);
    do_req(1'b0, 2'b10, 1'b0, 8'h08, 32'h0);
    chk("reinit_ld08", rsp_rdata, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

- Parametrised data-memory controller for the processor's load/store path, replacing the fixed 32-word, word-only scribble memory.
- Accepts one load or store per cycle over a valid/ready request channel and returns a registered response one cycle later.
- Supports byte, half and word accesses: little-endian, with sign or zero extension on loads.
- Clears its storage with a multi-cycle init sequence after reset; requests are held off until the clear finishes.

## Interface
Parameters:
- DEPTH, 32, number of 32-bit words; any value >= 2.
- ADDR_WIDTH, $clog2(DEPTH)+2, byte-address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  one-cycle response strobe
- rsp_rdata  out  32  load result; 0 for stores and errors
- rsp_err  out  1  access fault, qualified by rsp_valid
- init_done  out  1  storage clear complete

## Operation
FSM states:
- INIT: writes 0 to mem[cnt], one word per cycle; cnt counts 0..DEPTH-1; req_ready=0. After the write of word DEPTH-1, moves to READY.
- READY: req_ready=1 every cycle; init_done=1. No response backpressure.

Accepted request, word index = req_addr[ADDR_WIDTH-1:2]:
- Error (rsp_err=1, no write, rsp_rdata=0) when:
  - the word index is >= DEPTH, or
  - req_size == 11.
- Load: the selected lane is extracted (byte lane = addr[1:0]; half lane = addr[1]), then sign- or zero-extended to 32 bits.
- Store: only the addressed lane(s) are written.
  - Byte store writes req_wdata[7:0].
  - Half store writes req_wdata[15:0].
  - Other bytes of the word are preserved.
- Memory writes take effect at the accepting clock edge.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0, state INIT, cnt=0.
- After rst deasserts, the clear takes DEPTH cycles; req_ready rises on cycle DEPTH.
- Latency: response on the cycle after acceptance, rsp_valid high for exactly one cycle per accepted request. Throughput is one request per cycle.
- Store then load to the same word on consecutive cycles: the load returns the new data. No bypass is needed because the write has already landed.
- With no request accepted, rsp_valid=0; rsp_rdata and rsp_err hold their last values.
- rst asserted mid-operation:
  - the in-flight response is dropped (rsp_valid=0 the next cycle);
  - partial clear progress is discarded and INIT restarts at cnt=0.
- Requests presented during INIT are not accepted and produce no response.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined: a misaligned access raises rsp_err=1, performs no write and returns rsp_rdata=0. Misaligned means a half access with addr[0]=1, or a word access with addr[1:0]!=0.
- DMEM_MISALIGN_TRAP_EN undefined: misalignment never raises an error. Low address bits are ignored: addr[0] for half accesses, addr[1:0] for word accesses. The access proceeds on the aligned lane.

## Structure
- Package dmem_pkg holds:
  - typedef enum for access size: SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD;
  - typedef enum for FSM state: INIT, READY.
- Sub-module dmem_lane_align, combinational:
  - load path: lane extraction plus sign/zero extension;
  - store path: lane merge of write data into the old word with byte-enable generation.
- dmem_ctrl owns the storage array, the FSM, the init counter and the response registers.

## Test plan
- Reset, then hold req_valid=1:
  - req_ready stays 0 for DEPTH cycles (32 at default), then rises;
  - a word load from 0x00 returns 0x00000000.
- Store word 0x80FF7F01 @0x04, then load byte @0x04 signed -> 0x00000001.
  - Byte @0x07 signed -> 0xFFFFFF80.
  - Half @0x06 unsigned -> 0x000080FF.
  - Half @0x04 signed -> 0x00007F01.
- Store byte 0xAA @0x09 over word 0x11223344 @0x08, then load word @0x08 -> 0x1122AA44.
- Back-to-back: store word 0xDEADBEEF @0x10 in cycle n, load @0x10 in cycle n+1 -> rsp_rdata=0xDEADBEEF in cycle n+2.
  - rsp_valid is high in cycles n+1 and n+2.
- Error cases:
  - word index DEPTH -> rsp_err=1, rsp_rdata=0;
  - size 11 -> rsp_err=1;
  - word load @0x02 -> rsp_err=1 with DMEM_MISALIGN_TRAP_EN, else returns the word @0x00 with rsp_err=0.
- Assert rst the cycle after accepting a load:
  - rsp_valid=0 next cycle;
  - init_done=0;
  - the full DEPTH-cycle clear reruns, and previously stored data reads back 0.
